// File: rtl/angle_pkg.sv
// Shared constants and state encoding for the angle-sensor UART link (rx parser and tx sequencer).
package angle_pkg;

   localparam logic [7:0]  ANG_HEAD        = 8'hAA;
   localparam logic [7:0]  ANG_TAIL        = 8'h55;
   localparam int unsigned ANG_PAYLOAD_LEN = 6;

   // Command bytes issued by the transmit sequencer
   localparam logic [7:0]  ANG_CMD_SYNC    = 8'hA5;
   localparam logic [7:0]  ANG_CMD_QUERY   = 8'h51;
   localparam logic [7:0]  ANG_CMD_CAL     = 8'h52;
   localparam logic [7:0]  ANG_CMD_MODE    = 8'h54;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PAYLOAD,
      ST_TAIL
   } ang_state_t;

endpackage

// File: rtl/frame_timeout.sv
// Inter-byte watchdog: counts while enabled, clear has priority and suppresses the terminal pulse.
// tc is combinational and fires on the cycle the count would reach LIMIT.
module frame_timeout #(
   parameter int unsigned LIMIT = 104200
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] cnt;

   assign tc = en && !clr && (cnt == W'(LIMIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || tc) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/angle_frame_rx.sv
// Parses the 8-byte AA..55 angle reply into yaw/pitch/roll; outputs update one cycle after the tail strobe.
// No backpressure: every rx_done byte is consumed; stalled or malformed frames pulse frame_err.
module angle_frame_rx
   import angle_pkg::*;
#(
   parameter logic [7:0]  HEAD        = ANG_HEAD,
   parameter logic [7:0]  TAIL        = ANG_TAIL,
   parameter int unsigned PAYLOAD_LEN = ANG_PAYLOAD_LEN,
   parameter int unsigned TIMEOUT_CYC = 104200
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rx_done,
   input  logic [7:0]         rx_data,
   output logic signed [15:0] yaw,
   output logic signed [15:0] pitch,
   output logic signed [15:0] roll,
   output logic               frame_valid,
   output logic               frame_err,
   output logic [7:0]         frame_cnt,
   output logic               busy
);

   localparam logic [2:0] LAST_IDX = 3'(PAYLOAD_LEN - 1);

   ang_state_t state;
   logic [2:0] idx;
   logic [7:0] shadow [PAYLOAD_LEN];
   logic       to_clr;
   logic       to_tc;

   assign to_clr = rx_done || (state == ST_IDLE);
   assign busy   = (state != ST_IDLE);

   frame_timeout #(.LIMIT(TIMEOUT_CYC)) u_timeout (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (to_clr),
      .en    (busy),
      .tc    (to_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         idx         <= '0;
         yaw         <= '0;
         pitch       <= '0;
         roll        <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         frame_cnt   <= '0;
         for (int i = 0; i < int'(PAYLOAD_LEN); i++) shadow[i] <= '0;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rx_done && rx_data == HEAD) begin
                  state <= ST_PAYLOAD;
                  idx   <= '0;
               end
            end
            ST_PAYLOAD: begin
               if (rx_done) begin
                  shadow[idx] <= rx_data;
                  idx         <= idx + 3'd1;
                  if (idx == LAST_IDX) state <= ST_TAIL;
               end else if (to_tc) begin
                  frame_err <= 1'b1;
                  state     <= ST_IDLE;
                  idx       <= '0;
               end
            end
            ST_TAIL: begin
               if (rx_done) begin
                  // A wrong tail byte is dropped outright, never re-used as a header
                  if (rx_data == TAIL) begin
                     yaw         <= {shadow[0], shadow[1]};
                     pitch       <= {shadow[2], shadow[3]};
                     roll        <= {shadow[4], shadow[5]};
                     frame_valid <= 1'b1;
                     frame_cnt   <= frame_cnt + 8'd1;
                  end else begin
                     frame_err <= 1'b1;
                  end
                  state <= ST_IDLE;
                  idx   <= '0;
               end else if (to_tc) begin
                  frame_err <= 1'b1;
                  state     <= ST_IDLE;
                  idx       <= '0;
               end
            end
            default: begin
               state <= ST_IDLE;
               idx   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_angle_frame_rx.sv
// Scoreboard bench for angle_frame_rx: stimulus pushes expected pulses, a negedge monitor pops and compares.
module tb_angle_frame_rx;
   import angle_pkg::*;

   localparam int T = 200;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               rx_done = 1'b0;
   logic [7:0]         rx_data = 8'h00;
   logic signed [15:0] yaw, pitch, roll;
   logic               frame_valid, frame_err, busy;
   logic [7:0]         frame_cnt;

   angle_frame_rx #(.TIMEOUT_CYC(T)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_done     (rx_done),
      .rx_data     (rx_data),
      .yaw         (yaw),
      .pitch       (pitch),
      .roll        (roll),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .frame_cnt   (frame_cnt),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         is_err;
      logic [15:0] y, p, r;
      logic [7:0]  c;
      int          at;
   } exp_t;

   exp_t sbq[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   last_edge = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input bit is_err, input logic [15:0] y, input logic [15:0] p,
                           input logic [15:0] r, input logic [7:0] c, input int at);
      exp_t e;
      e.is_err = is_err; e.y = y; e.p = p; e.r = r; e.c = c; e.at = at;
      sbq.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n && (frame_valid || frame_err)) begin
         check("pulse_exclusive", {31'b0, frame_valid & frame_err}, 32'd0);
         if (sbq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_pulse: valid=%0b err=%0b at cycle %0d, none expected",
                     frame_valid, frame_err, cyc);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("pulse_kind_err", {31'b0, frame_err}, {31'b0, e.is_err});
            check("yaw", {16'h0, yaw}, {16'h0, e.y});
            check("pitch", {16'h0, pitch}, {16'h0, e.p});
            check("roll", {16'h0, roll}, {16'h0, e.r});
            check("frame_cnt", {24'h0, frame_cnt}, {24'h0, e.c});
            if (e.at >= 0) check("pulse_cycle", cyc, e.at);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobe(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      @(posedge clk);
      #1;
      last_edge = cyc;
      rx_done = 1'b0;
      rx_data = 8'($urandom);
   endtask

   task automatic send_frame(input logic [7:0] f [8], input int gap);
      for (int k = 0; k < 8; k++) begin
         idle(gap);
         strobe(f[k]);
      end
   endtask

   logic [7:0]  fr [8];
   logic [15:0] y, p, r;

   initial begin
      idle(3);
      check("rst_yaw", {16'h0, yaw}, 32'd0);
      check("rst_pitch", {16'h0, pitch}, 32'd0);
      check("rst_roll", {16'h0, roll}, 32'd0);
      check("rst_frame_cnt", {24'h0, frame_cnt}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_frame_valid", {31'b0, frame_valid}, 32'd0);
      check("rst_frame_err", {31'b0, frame_err}, 32'd0);
      rst_n = 1'b1;
      idle(2);

      // Good frame, bytes 100 cycles apart; valid on the tail's edge
      fr = '{8'hAA, 8'h01, 8'h2C, 8'hFF, 8'h38, 8'h00, 8'h00, 8'h55};
      push_exp(0, 16'd300, 16'hFF38, 16'd0, 8'd1, cyc + 8 * 100);
      send_frame(fr, 99);
      check("busy_after_frame", {31'b0, busy}, 32'd0);

      // Bad tail (AA) then a headerless run that must be ignored
      fr = '{8'hAA, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hAA};
      push_exp(1, 16'd300, 16'hFF38, 16'd0, 8'd1, cyc + 8);
      send_frame(fr, 0);
      fr = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h55, 8'h00};
      send_frame(fr, 0);
      check("busy_after_bad_tail", {31'b0, busy}, 32'd0);

      // Stall after AA 01: error exactly T cycles after the last strobe
      strobe(8'hAA);
      strobe(8'h01);
      push_exp(1, 16'd300, 16'hFF38, 16'd0, 8'd1, last_edge + T);
      check("busy_mid_frame", {31'b0, busy}, 32'd1);
      idle(T + 5);
      check("busy_after_timeout", {31'b0, busy}, 32'd0);

      // Garbage in IDLE, then a good frame
      strobe(8'h00); idle(3);
      strobe(8'hFF); idle(3);
      strobe(8'h55); idle(3);
      fr = '{8'hAA, 8'h00, 8'h0A, 8'h00, 8'h14, 8'h00, 8'h1E, 8'h55};
      push_exp(0, 16'd10, 16'd20, 16'd30, 8'd2, cyc + 8 * 3);
      send_frame(fr, 2);

      // AA inside payload; two bytes land on the exact terminal-count cycle
      push_exp(0, 16'hAAAA, 16'h0001, 16'h8000, 8'd3, -1);
      strobe(8'hAA);
      strobe(8'hAA);
      strobe(8'hAA);
      strobe(8'h00);
      idle(T - 1);
      strobe(8'h01);
      idle(T - 1);
      strobe(8'h80);
      strobe(8'h00);
      strobe(8'h55);
      idle(3);
      check("busy_after_tc_frame", {31'b0, busy}, 32'd0);

      // Asynchronous reset mid-frame clears outputs at once
      strobe(8'hAA);
      strobe(8'h01);
      strobe(8'h2C);
      rst_n = 1'b0;
      #1;
      check("arst_yaw", {16'h0, yaw}, 32'd0);
      check("arst_pitch", {16'h0, pitch}, 32'd0);
      check("arst_roll", {16'h0, roll}, 32'd0);
      check("arst_frame_cnt", {24'h0, frame_cnt}, 32'd0);
      check("arst_busy", {31'b0, busy}, 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(2);

      // 256 back-to-back frames after reset: counter wraps to 0
      for (int i = 0; i < 256; i++) begin
         y = 16'(i);
         p = 16'(-i);
         r = 16'(3 * i);
         fr = '{8'hAA, y[15:8], y[7:0], p[15:8], p[7:0], r[15:8], r[7:0], 8'h55};
         push_exp(0, y, p, r, 8'((i + 1) % 256), -1);
         send_frame(fr, 0);
      end
      idle(3);
      check("frame_cnt_wrap", {24'h0, frame_cnt}, 32'd0);
      check("scoreboard_drained", sbq.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
